// File: rtl/serial_add_sub_unit_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
// The master side issues operands and accepts results; the slave side is the unit.
interface serial_add_sub_unit_if #(
   parameter int WIDTH = 4
);
   logic             in_valid_i;
   logic             in_ready_o;
   logic [WIDTH-1:0] a_i;
   logic [WIDTH-1:0] b_i;
   logic             sub_i;
   logic             cin_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [WIDTH-1:0] s_o;
   logic             cout_o;
   logic             ovf_o;

   modport master (
      output in_valid_i, a_i, b_i, sub_i, cin_i, out_ready_i,
      input  in_ready_o, out_valid_o, s_o, cout_o, ovf_o
   );

   modport slave (
      input  in_valid_i, a_i, b_i, sub_i, cin_i, out_ready_i,
      output in_ready_o, out_valid_o, s_o, cout_o, ovf_o
   );
endinterface

// File: rtl/serial_add_sub_unit.sv
// Bit-serial WIDTH-bit adder/subtractor, one bit per clock, LSB first.
// Subtraction is a + ~b + ~borrow_in; the carry-out is inverted to give a borrow.
// Results match a combinational ripple adder/subtractor: sum, carry/borrow, overflow.
module serial_add_sub_unit #(
   parameter int WIDTH = 4
) (
   input logic                 clk_i,
   input logic                 rst_n_i,
   serial_add_sub_unit_if.slave bus
);
   localparam int                CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             cout_q;
   logic             ovf_q;
   logic             carry_q;
   logic             sub_q;
   logic [CNT_W-1:0] bit_cnt;
   logic [WIDTH-1:0] s_q;

   // Operand shift registers and partial result (pure datapath, no reset)
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-2:0] s_work;
   logic [WIDTH-1:0] s_next;

   logic a_bit;
   logic b_bit;
   logic s_bit;
   logic carry_nxt;
   logic accept;
   logic last_step;

   function automatic logic maj3(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

   // b is stored already conditioned by sub, so each step is a plain full add
   assign a_bit     = a_sh[0];
   assign b_bit     = b_sh[0];
   assign s_bit     = a_bit ^ b_bit ^ carry_q;
   assign carry_nxt = maj3(a_bit, b_bit, carry_q);
   assign s_next    = {s_bit, s_work};

   assign accept    = (state == IDLE) && in_ready_q && bus.in_valid_i;
   assign last_step = (state == CALC) && (bit_cnt == LAST_BIT);

   // Control FSM: handshakes, bit counter, carry flop and registered results
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state       <= IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         s_q         <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         carry_q     <= 1'b0;
         sub_q       <= 1'b0;
         bit_cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  sub_q      <= bus.sub_i;
                  carry_q    <= bus.sub_i ? ~bus.cin_i : bus.cin_i;
                  bit_cnt    <= '0;
                  in_ready_q <= 1'b0;
                  state      <= CALC;
               end else begin
                  in_ready_q <= 1'b1;
               end
            end
            CALC: begin
               carry_q <= carry_nxt;
               bit_cnt <= bit_cnt + CNT_W'(1);
               if (last_step) begin
                  s_q         <= s_next;
                  ovf_q       <= carry_q ^ carry_nxt;
                  cout_q      <= sub_q ? ~carry_nxt : carry_nxt;
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready_i) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               state       <= IDLE;
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Operand capture on accept, then shift one bit per cycle while calculating
   always_ff @(posedge clk_i) begin
      if (accept) begin
         a_sh <= bus.a_i;
         b_sh <= bus.b_i ^ {WIDTH{bus.sub_i}};
      end else if (state == CALC) begin
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         s_work <= s_next[WIDTH-1:1];
      end
   end

   assign bus.in_ready_o  = in_ready_q;
   assign bus.out_valid_o = out_valid_q;
   assign bus.s_o         = s_q;
   assign bus.cout_o      = cout_q;
   assign bus.ovf_o       = ovf_q;
endmodule

// File: tb/tb_serial_add_sub_unit.sv
// Scoreboard bench for serial_add_sub_unit: driver pushes model results,
// a negedge monitor pops and compares on every output handshake.
`timescale 1ns/1ps
module tb_serial_add_sub_unit;
   localparam int W = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   last_acc = 0;
   logic [W+1:0] sb_q[$];
   logic rand_rdy = 1'b0;
   logic fix_rdy  = 1'b0;
   logic rnd_rdy  = 1'b0;
   logic ov_seen  = 1'b0;

   serial_add_sub_unit_if #(.WIDTH(W)) bus ();

   serial_add_sub_unit #(.WIDTH(W)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      rnd_rdy <= ($urandom_range(0, 3) != 0);
   end

   assign bus.out_ready_i = rand_rdy ? rnd_rdy : fix_rdy;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: integer arithmetic on unsigned and signed interpretations
   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sub, input logic cin);
      int ua, ub, sa, sbv, full, sres;
      logic [W-1:0] s;
      logic co, ov;
      ua  = int'(a);
      ub  = int'(b);
      sa  = (ua >= 2**(W-1)) ? ua - 2**W : ua;
      sbv = (ub >= 2**(W-1)) ? ub - 2**W : ub;
      if (!sub) begin
         full = ua + ub + int'(cin);
         co   = (full >= 2**W);
         sres = sa + sbv + int'(cin);
      end else begin
         full = ua - ub - int'(cin);
         co   = (full < 0);
         sres = sa - sbv - int'(cin);
      end
      s  = full[W-1:0];
      ov = (sres > 2**(W-1) - 1) || (sres < -(2**(W-1)));
      return {s, co, ov};
   endfunction

   // Monitor: latency on rising valid, scoreboard compare on handshake
   always @(negedge clk) begin
      if (!rst_n) begin
         ov_seen <= 1'b0;
      end else if (bus.out_valid_o) begin
         if (!ov_seen) begin
            chk("latency", cyc - last_acc, W);
            ov_seen <= 1'b1;
         end
         if (bus.out_ready_i) begin
            if (sb_q.size() == 0) chk("unexpected_result", 1, 0);
            else chk("result", int'({bus.s_o, bus.cout_o, bus.ovf_o}), int'(sb_q.pop_front()));
            ov_seen <= 1'b0;
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the accepting edge
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic cin);
      int n = 0;
      while (bus.in_ready_o !== 1'b1) begin
         @(posedge clk); #1;
         n++;
         if (n > 100) begin
            chk("in_ready_timeout", 0, 1);
            return;
         end
      end
      bus.a_i = a; bus.b_i = b; bus.sub_i = sub; bus.cin_i = cin;
      bus.in_valid_i = 1'b1;
      @(posedge clk); #1;
      last_acc = cyc;
      sb_q.push_back(model(a, b, sub, cin));
      bus.in_valid_i = 1'b0;
      bus.a_i   = W'($urandom);
      bus.b_i   = W'($urandom);
      bus.sub_i = 1'($urandom);
      bus.cin_i = 1'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0) begin
         @(posedge clk); #1;
         n++;
         if (n > 200) begin
            chk("drain_timeout", sb_q.size(), 0);
            sb_q.delete();
            return;
         end
      end
   endtask

   task automatic wait_valid();
      int n = 0;
      while (bus.out_valid_o !== 1'b1) begin
         @(posedge clk); #1;
         n++;
         if (n > 50) begin
            chk("valid_timeout", 0, 1);
            return;
         end
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid_i = 1'b0;
      bus.a_i = '0; bus.b_i = '0; bus.sub_i = 1'b0; bus.cin_i = 1'b0;
      #12;
      chk("rst_in_ready", bus.in_ready_o, 0);
      chk("rst_out_valid", bus.out_valid_o, 0);
      chk("rst_s", bus.s_o, 0);
      chk("rst_cout", bus.cout_o, 0);
      chk("rst_ovf", bus.ovf_o, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("in_ready_after_reset", bus.in_ready_o, 1);

      // Directed vectors
      fix_rdy = 1'b1;
      send(4'b0111, 4'b0001, 1'b0, 1'b0);
      send(4'b1111, 4'b0001, 1'b0, 1'b1);
      send(4'b0011, 4'b0101, 1'b1, 1'b0);
      send(4'b1000, 4'b0001, 1'b1, 1'b0);
      drain();

      // Backpressure with an ignored concurrent request
      fix_rdy = 1'b0;
      send(4'b0110, 4'b0011, 1'b0, 1'b1);
      wait_valid();
      bus.a_i = 4'b0001; bus.b_i = 4'b0001; bus.sub_i = 1'b0; bus.cin_i = 1'b0;
      bus.in_valid_i = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("bp_hold", int'({bus.s_o, bus.cout_o, bus.ovf_o}),
             int'(model(4'b0110, 4'b0011, 1'b0, 1'b1)));
         chk("bp_in_ready", bus.in_ready_o, 0);
         chk("bp_valid", bus.out_valid_o, 1);
      end
      bus.in_valid_i = 1'b0;
      fix_rdy = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_ready", bus.in_ready_o, 1);
      chk("bp_release_valid", bus.out_valid_o, 0);
      send(4'b1001, 4'b0100, 1'b1, 1'b1);
      drain();

      // Reset in the middle of a calculation
      send(4'b0101, 4'b0110, 1'b0, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", bus.out_valid_o, 0);
      chk("rst_mid_in_ready", bus.in_ready_o, 0);
      chk("rst_mid_s", bus.s_o, 0);
      sb_q.delete();
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_release_ready", bus.in_ready_o, 1);
      repeat (W + 3) begin
         @(posedge clk); #1;
         chk("no_stale", bus.out_valid_o, 0);
      end

      // Exhaustive sweep with random consumer stalls and idle gaps
      rand_rdy = 1'b1;
      for (int v = 0; v < 2**(2*W+2); v++) begin
         send(v[3:0], v[7:4], v[8], v[9]);
         if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      for (int k = 0; k < 200; k++)
         send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/serial_add_sub_unit.md
Name: serial_add_sub_unit

Overview:
- Bit-serial WIDTH-bit adder/subtractor with valid/ready handshakes on both its input and output sides.
- It is the sequential counterpart to the combinational four-bit full adder and four-bit full subtractor blocks.
- It produces results bit-identical to theirs: sum/difference, carry/borrow-out and signed overflow.
- The same generic test harness drives it through its own virtual-interface wrapper.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..16).

Ports:
- clk_i  input  1  rising-edge system clock
- rst_n_i  input  1  asynchronous active-low reset
- in_valid_i  input  1  operand transaction valid
- in_ready_o  output  1  unit can accept operands
- a_i  input  WIDTH  operand A (unsigned/two's complement)
- b_i  input  WIDTH  operand B
- sub_i  input  1  0 = add, 1 = subtract
- cin_i  input  1  carry-in (add) or borrow-in (subtract)
- out_valid_o  output  1  result valid
- out_ready_i  input  1  consumer accepts result
- s_o  output  WIDTH  sum/difference
- cout_o  output  1  carry-out (add) or borrow-out (subtract)
- ovf_o  output  1  signed overflow

Behaviour:
- Reset (rst_n_i low, asynchronous):
  - State goes to IDLE.
  - in_ready_o=0 while reset is asserted, then 1 from the first cycle in IDLE.
  - out_valid_o=0, s_o=0, cout_o=0, ovf_o=0.
  - Bit counter and carry flip-flop are cleared.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready_o=1, out_valid_o=0.
  - On a clock edge with in_valid_i=1, the unit latches a_i, b_i, sub_i and cin_i, loads the carry flop, clears the bit counter and goes to CALC.
  - Carry flop load value: cin_i for add; ~cin_i for subtract.
- CALC:
  - in_ready_o=0. One bit per edge, LSB first.
  - Per bit: bb = b[i] XOR sub; s[i] = a[i] ^ bb ^ c; c <= majority(a[i], bb, c).
  - The result is shifted into the s register MSB-first, so after WIDTH edges it is right-aligned.
  - On the edge processing bit WIDTH-1, the unit registers the final values and goes to DONE:
    - ovf = (carry into MSB) XOR (carry out of MSB).
    - cout = final carry for add; ~final carry for subtract (borrow).
- Latency: out_valid_o rises exactly WIDTH clock edges after the accepting edge.
- DONE:
  - out_valid_o=1; s_o, cout_o and ovf_o are stable while valid.
  - When out_ready_i=1 at an edge, out_valid_o falls and the state goes to IDLE.
  - in_ready_o=0 in DONE. No same-cycle re-accept, so throughput is one transaction per WIDTH+2 cycles.
- Output persistence:
  - s_o, cout_o and ovf_o hold their last values after the handshake until the next completion.
  - They are only meaningful while out_valid_o=1.
- Input sampling:
  - Operand inputs are sampled only on the accepting edge.
  - Changes to them during CALC or DONE have no effect.
- Handshake rules:
  - in_valid_i while in CALC or DONE is ignored and not queued.
  - out_ready_i high while out_valid_o=0 has no effect.
- Reset mid-operation (CALC or DONE):
  - The transaction is discarded and no result is produced.
  - All outputs take their reset values immediately.
- Arithmetic:
  - Modulo 2^WIDTH.
  - Results must match the combinational adder/subtractor reference model for all inputs.

Test Plan:
- Add: a=0111, b=0001, sub=0, cin=0 -> s=1000, cout=0, ovf=1; out_valid_o high 4 edges after accept.
- Add wrap: a=1111, b=0001, cin=1 -> s=0001, cout=1, ovf=0.
- Subtract: a=0011, b=0101, sub=1, cin=0 -> s=1110, cout(borrow)=1, ovf=0.
- Subtract overflow: a=1000, b=0001, sub=1, cin=0 -> s=0111, cout=0, ovf=1.
- Backpressure:
  - Hold out_ready_i=0 for 3 cycles after valid -> s_o, cout_o and ovf_o stay stable and in_ready_o stays 0.
  - A concurrent in_valid_i with a=0001, b=0001 is ignored.
  - After out_ready_i=1, in_ready_o=1 on the next cycle and a new transaction completes correctly.
- Reset and exhaustive:
  - Assert rst_n_i low mid-CALC (after 2 edges) -> out_valid_o=0 and in_ready_o=0 immediately; in_ready_o=1 after release; no stale result appears.
  - Exhaustive sweep over all 2^(2*4+2) combinations matches the reference model.
